// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB master sequencer.
//   state_t    : sequencer FSM states
//   phase_t    : which 9-bit phase of a transaction is on the bus
//   phase_byte : byte transmitted (MSB first) during a given phase
package sccb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_WAIT,
        START_HOLD,
        BIT,
        STOP_LOW,
        STOP_HIGH,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        PH_ID_W,
        PH_ADDR,
        PH_DATA,
        PH_ID_R,
        PH_RDATA
    } phase_t;

    localparam logic SCCB_WRITE_BIT = 1'b0;
    localparam logic SCCB_READ_BIT  = 1'b1;
    localparam logic NA_BIT         = 1'b1;

    // The read-data phase transmits nothing; its byte is never driven.
    function automatic logic [7:0] phase_byte(
        input phase_t     ph,
        input logic [6:0] id,
        input logic [7:0] addr,
        input logic [7:0] wdata
    );
        logic [7:0] b;
        b = 8'h00;
        case (ph)
            PH_ID_W: b = {id, SCCB_WRITE_BIT};
            PH_ADDR: b = addr;
            PH_DATA: b = wdata;
            PH_ID_R: b = {id, SCCB_READ_BIT};
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sccb_edge_detect.sv
// Registers the divider's sccb_clk and flags its edges, one clk wide.
//   clk, resetn : system clock, async active-low reset
//   sccb_clk    : divider SCCB clock (idles high)
//   rise, fall  : one-cycle edge strobes
module sccb_edge_detect (
    input  logic clk,
    input  logic resetn,
    input  logic sccb_clk,
    output logic rise,
    output logic fall
);

    logic sclk_q;

    // Reset to 1 so a bus that comes out of reset high shows no false edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sclk_q <= 1'b1;
        else         sclk_q <= sccb_clk;
    end

    assign rise = sccb_clk & ~sclk_q;
    assign fall = ~sccb_clk & sclk_q;

endmodule

// File: rtl/sccb_master_ctrl.sv
// SCCB transaction sequencer. Takes one register write or read per
// valid/ready handshake and drives SIOC/SIOD with start, stop and 9th-bit
// handling, paced by the sibling divider's sccb_clk and mid_pulse.
//   clk, resetn         : system clock, async active-low reset
//   sccb_clk, mid_pulse : divider clock and mid-low strobe
//   req_*               : request handshake (rw, 7-bit id, addr, wdata)
//   rsp_valid, rd_data  : completion pulse and read byte
//   busy                : transaction in progress
//   sioc, siod_out, siod_oe, siod_in : SCCB pad signals
module sccb_master_ctrl
    import sccb_pkg::*;
#(
    parameter bit RELEASE_DC = 1'b1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       sccb_clk,
    input  logic       mid_pulse,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_id,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       sioc,
    output logic       siod_out,
    output logic       siod_oe,
    input  logic       siod_in
);

    logic sclk_rise, sclk_fall;

    sccb_edge_detect u_edge (
        .clk      (clk),
        .resetn   (resetn),
        .sccb_clk (sccb_clk),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    state_t     state_reg, state_next;
    phase_t     phase_reg, phase_next;
    logic [3:0] bit_idx_reg, bit_idx_next;
    logic       rw_reg, rw_next;
    logic [6:0] id_reg, id_next;
    logic [7:0] addr_reg, addr_next;
    logic [7:0] wdata_reg, wdata_next;
    logic [7:0] rd_shift_reg, rd_shift_next;
    logic       rd_pending_reg, rd_pending_next;
    logic       sioc_reg, sioc_next;
    logic       siod_out_reg, siod_out_next;
    logic       siod_oe_reg, siod_oe_next;
    logic       req_ready_reg, req_ready_next;
    logic       busy_reg, busy_next;
    logic       rsp_valid_reg, rsp_valid_next;
    logic [7:0] rd_data_reg, rd_data_next;

    logic [7:0] tx_byte;
    logic [2:0] tx_sel;

    assign tx_byte = phase_byte(phase_reg, id_reg, addr_reg, wdata_reg);
    // bit_idx 8..1 maps to byte bit 7..0 (8 wraps to 0, minus one gives 7).
    assign tx_sel  = bit_idx_reg[2:0] - 3'd1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            phase_reg      <= PH_ID_W;
            bit_idx_reg    <= 4'd0;
            rw_reg         <= 1'b0;
            id_reg         <= 7'd0;
            addr_reg       <= 8'd0;
            wdata_reg      <= 8'd0;
            rd_shift_reg   <= 8'd0;
            rd_pending_reg <= 1'b0;
            sioc_reg       <= 1'b1;
            siod_out_reg   <= 1'b1;
            siod_oe_reg    <= 1'b1;
            req_ready_reg  <= 1'b1;
            busy_reg       <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rd_data_reg    <= 8'd0;
        end else begin
            state_reg      <= state_next;
            phase_reg      <= phase_next;
            bit_idx_reg    <= bit_idx_next;
            rw_reg         <= rw_next;
            id_reg         <= id_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            rd_shift_reg   <= rd_shift_next;
            rd_pending_reg <= rd_pending_next;
            sioc_reg       <= sioc_next;
            siod_out_reg   <= siod_out_next;
            siod_oe_reg    <= siod_oe_next;
            req_ready_reg  <= req_ready_next;
            busy_reg       <= busy_next;
            rsp_valid_reg  <= rsp_valid_next;
            rd_data_reg    <= rd_data_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        phase_next      = phase_reg;
        bit_idx_next    = bit_idx_reg;
        rw_next         = rw_reg;
        id_next         = id_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        rd_shift_next   = rd_shift_reg;
        rd_pending_next = rd_pending_reg;
        siod_out_next   = siod_out_reg;
        siod_oe_next    = siod_oe_reg;
        req_ready_next  = req_ready_reg;
        busy_next       = busy_reg;
        rsp_valid_next  = 1'b0;
        rd_data_next    = rd_data_reg;
        // SIOC only toggles while bits or the stop setup are on the bus.
        sioc_next       = (state_reg == BIT || state_reg == STOP_LOW) ? sccb_clk : 1'b1;

        case (state_reg)
            IDLE: begin
                req_ready_next = 1'b1;
                if (req_valid && req_ready_reg) begin
                    rw_next         = req_rw;
                    id_next         = req_id;
                    addr_next       = req_addr;
                    wdata_next      = req_wdata;
                    req_ready_next  = 1'b0;
                    busy_next       = 1'b1;
                    phase_next      = PH_ID_W;
                    rd_pending_next = 1'b0;
                    state_next      = START_WAIT;
                end
            end
            START_WAIT: begin
                // SIOD falls while SIOC is held high: start condition.
                if (sclk_rise) begin
                    siod_out_next = 1'b0;
                    siod_oe_next  = 1'b1;
                    state_next    = START_HOLD;
                end
            end
            START_HOLD: begin
                if (sclk_fall) begin
                    bit_idx_next = 4'd8;
                    state_next   = BIT;
                end
            end
            BIT: begin
                if (mid_pulse) begin
                    if (bit_idx_reg != 4'd0) begin
                        if (phase_reg == PH_RDATA) begin
                            siod_out_next = 1'b1;
                            siod_oe_next  = 1'b0;
                        end else begin
                            siod_out_next = tx_byte[tx_sel];
                            siod_oe_next  = 1'b1;
                        end
                    end else if (phase_reg == PH_RDATA) begin
                        siod_out_next = NA_BIT;
                        siod_oe_next  = 1'b1;
                    end else if (RELEASE_DC) begin
                        siod_out_next = 1'b1;
                        siod_oe_next  = 1'b0;
                    end else begin
                        siod_out_next = 1'b0;
                        siod_oe_next  = 1'b1;
                    end
                end
                if (sclk_rise && phase_reg == PH_RDATA && bit_idx_reg != 4'd0) begin
                    rd_shift_next = {rd_shift_reg[6:0], siod_in};
                end
                if (sclk_fall) begin
                    if (bit_idx_reg != 4'd0) begin
                        bit_idx_next = bit_idx_reg - 4'd1;
                    end else begin
                        bit_idx_next = 4'd8;
                        case (phase_reg)
                            PH_ID_W: phase_next = PH_ADDR;
                            PH_ADDR: begin
                                if (rw_reg) begin
                                    // Read: close the address write, restart later.
                                    rd_pending_next = 1'b1;
                                    state_next      = STOP_LOW;
                                end else begin
                                    phase_next = PH_DATA;
                                end
                            end
                            PH_ID_R: phase_next = PH_RDATA;
                            default: state_next = STOP_LOW;
                        endcase
                    end
                end
            end
            STOP_LOW: begin
                if (mid_pulse) begin
                    siod_out_next = 1'b0;
                    siod_oe_next  = 1'b1;
                end
                if (sclk_rise) state_next = STOP_HIGH;
            end
            STOP_HIGH: begin
                // SIOD rises while SIOC is held high: stop condition.
                if (sclk_fall) begin
                    siod_out_next = 1'b1;
                    if (rd_pending_reg) begin
                        rd_pending_next = 1'b0;
                        phase_next      = PH_ID_R;
                        state_next      = START_WAIT;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                rsp_valid_next = 1'b1;
                if (rw_reg) rd_data_next = rd_shift_reg;
                busy_next      = 1'b0;
                req_ready_next = 1'b1;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign req_ready = req_ready_reg;
    assign busy      = busy_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rd_data   = rd_data_reg;
    assign sioc      = sioc_reg;
    assign siod_out  = siod_out_reg;
    assign siod_oe   = siod_oe_reg;

endmodule

// File: doc/sccb_master_ctrl.md
Name: sccb_master_ctrl

Overview:
- SCCB (OV-camera register bus) transaction sequencer, driven by the sibling SCCB clock divider's `sccb_clk` and `mid_pulse` outputs. The divider is instantiated next to this block at the camera-control top level.
- Accepts one register-write or register-read request per valid/ready handshake and produces SIOC/SIOD with start, stop and 9th-bit handling.
- Write is a 3-phase write. Read is a 2-phase write, a stop, then a 2-phase read.
- Returns read data and a completion pulse to the CPU-side register interface.

Parameters:
- RELEASE_DC, 1: 1 = tri-state SIOD (`siod_oe`=0) on the 9th (don't-care) bit of master-transmitted phases; 0 = drive 0 on that bit.

Ports:
- `clk` in 1: system clock; same clock as the divider.
- `resetn` in 1: asynchronous, active-low reset.
- `sccb_clk` in 1: divider SCCB clock; idles high.
- `mid_pulse` in 1: divider one-`clk` pulse at mid-low of `sccb_clk`.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_rw` in 1: 0 = write, 1 = read.
- `req_id` in 7: 7-bit device ID.
- `req_addr` in 8: sub-address.
- `req_wdata` in 8: write data.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rd_data` out 8: read byte; valid with `rsp_valid` when `req_rw`=1.
- `busy` out 1: transaction in progress.
- `sioc` out 1: SCCB clock to pad.
- `siod_out` out 1: SIOD drive value.
- `siod_oe` out 1: SIOD output enable.
- `siod_in` in 1: SIOD pad input.

Behaviour:
- Reset values (async assert, sync release):
  - `sioc`=1, `siod_out`=1, `siod_oe`=1, `req_ready`=1, `busy`=0, `rsp_valid`=0, `rd_data`=0.
  - State=IDLE; internal `sclk_q`=1.
- Edge events come from `sclk_q` (registered `sccb_clk`): RISE = `sccb_clk` & ~`sclk_q`; FALL = ~`sccb_clk` & `sclk_q`; MID = `mid_pulse`.
- All outputs are registered. Inside BIT and STOP_LOW, `sioc` <= `sccb_clk` (one-`clk` lag); otherwise `sioc` is held at 1.
- IDLE:
  - `req_ready`=1.
  - On `req_valid` & `req_ready`: latch `req_*`; `req_ready`<=0, `busy`<=1; phase<=0; go START_WAIT.
- START_WAIT: on RISE, `siod_out`<=0 (start condition: SIOD falls while SIOC is high); go START_HOLD.
- START_HOLD: on FALL, bit_idx<=8; go BIT.
- BIT:
  - On MID:
    - bit_idx 8..1: drive the shift byte's MSB-first bit with `siod_oe`=1. Exception: read-data phase drives `siod_oe`=0.
    - bit_idx 0: write-type phases use RELEASE_DC. Read-data phase drives 1 (NA).
  - On RISE in read-data phase, bit_idx 8..1: shift `siod_in` into `rd_shift`.
  - On FALL: if bit_idx>0, decrement bit_idx. At 0, end the phase.
- Phase sequence:
  - Write: ID (`req_id`,0), ADDR, DATA, then STOP_LOW.
  - Read: ID (`req_id`,0), ADDR, STOP_LOW, START_WAIT, ID (`req_id`,1), RDATA, STOP_LOW.
  - Every new phase reloads bit_idx<=8.
- STOP_LOW: on MID, `siod_out`<=0, `siod_oe`<=1. On next RISE, freeze `sioc`=1; go STOP_HIGH.
- STOP_HIGH: on FALL, `siod_out`<=1 (stop condition).
  - If a read still has its second half pending, go START_WAIT.
  - Otherwise go DONE.
- DONE (one `clk`):
  - `rsp_valid`<=1; `rd_data`<=`rd_shift` on reads, unchanged on writes.
  - `busy`<=0, `req_ready`<=1; go IDLE.
  - `rsp_valid` deasserts next cycle.
- Requests while `busy` are not accepted (`req_ready`=0); `req_*` changes after acceptance are ignored.
- Latency:
  - Write = 29 `sccb_clk` periods (start + 27 bits + stop), ±1 period of start alignment.
  - Read = 2×(start + 18 bits + stop) = 40 periods.
- Reset mid-transaction: outputs return to reset values immediately, giving a bus-idle state. No partial stop is generated. No `rsp_valid` is issued.
- Simultaneous events: RISE and MID never coincide, per divider guarantee. The DONE-cycle request can only be accepted in the following IDLE cycle.

Decomposition:
- Shared package `sccb_pkg`:
  - State encoding: IDLE, START_WAIT, START_HOLD, BIT, STOP_LOW, STOP_HIGH, DONE.
  - Phase codes: PH_ID_W, PH_ADDR, PH_DATA, PH_ID_R, PH_RDATA.
  - Constants: SCCB_WRITE_BIT=0, SCCB_READ_BIT=1, NA_BIT=1.
- Natural sub-module: `sccb_edge_detect` (registers `sccb_clk`, emits RISE/FALL).
- `clock_divider` stays a sibling at top level.

Test Plan:
- Write `req_id`=0x21, addr=0x12, data=0x80 -> SIOD bytes 0x42, 0x12, 0x80 MSB-first, each sampled at SIOC rise; `siod_oe`=0 on each 9th bit; stop; `rsp_valid` 1 cycle; `busy` 0.
- Read `req_id`=0x21, addr=0x0A with a slave model returning 0x76 -> 0x42, 0x0A, stop, start, 0x43; master releases SIOD for 8 bits then drives NA=1; stop; `rd_data`=0x76 with `rsp_valid`.
- Start/stop legality -> SIOD transitions only while SIOC=0, except start (1→0) and stop (0→1) while SIOC=1; `sioc`=1 throughout IDLE.
- Back-to-back: `req_valid` held with two writes -> second accepted the cycle after DONE; `req_ready`=0 throughout the first; no overlap on bus.
- `resetn` pulsed low at bit 4 of the ADDR phase -> next cycle `sioc`=1, `siod_out`=1, `busy`=0, no `rsp_valid`; a following write completes normally.
- RELEASE_DC=0 -> 9th bit of each write phase driven 0 with `siod_oe`=1.
